// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder: FSM state
// encoding, default address/data widths and the wait-state counter type.
// Build option: DMEM_BYTE_EN (see dmem_responder) does not affect this file.
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam int DMEM_ADDR_W   = 7;
   localparam int DMEM_DATA_W   = 32;
   localparam int DMEM_WAIT_MAX = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef logic [3:0] cnt_t;

   // Counter preload on accept; the WAIT state is skipped entirely when
   // there are no wait states, so the value is irrelevant in that case.
   function automatic cnt_t wait_init(input int wait_cyc);
      return (wait_cyc > 0) ? cnt_t'(wait_cyc - 1) : '0;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x DATA_W storage with synchronous per-byte write and a registered
// read port. One access per en_i pulse: a write updates the enabled bytes and
// clears the read register (store responses carry zero data); a read loads
// the read register from the addressed word.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (read register only)
//   en_i         perform an access this edge
//   we_i         1 = write, 0 = read
//   be_i         per-byte write enables (bit i -> data[8i+7:8i])
//   addr_i       word address
//   wdata_i      write data
//   rdata_o      registered read data
// -----------------------------------------------------------------------------
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [DATA_W/8-1:0]   be_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int BE_W  = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the storage array has no reset branch; resetting a RAM forces it
   // into flops and a reset must not erase committed stores anyway.
   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (en_i) begin
         rdata_q <= we_i ? '0 : mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder at the far end of the ALU word-address path. Accepts
// one load/store at a time (valid/ready), inserts WAIT_CYC wait states,
// performs the access on the edge that enters RESP and holds the response
// until the consumer takes it.
// Build option: define DMEM_BYTE_EN to add req_be and byte-masked stores;
// without it every store writes the full word.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we                1 = store, 0 = load
//   req_addr, req_wdata   word address, store data
//   req_be                byte enables (DMEM_BYTE_EN only)
//   resp_valid/resp_ready response handshake
//   resp_rdata            load data, 0 for store responses
//   busy                  FSM not in IDLE
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int DATA_W   = DMEM_DATA_W,
   parameter int WAIT_CYC = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
`ifdef DMEM_BYTE_EN
   input  logic [DATA_W/8-1:0] req_be,
`endif
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                busy
);

   localparam int   BE_W     = DATA_W / 8;
   localparam cnt_t CNT_INIT = wait_init(WAIT_CYC);

   state_e            state_q, state_d;
   cnt_t              cnt_q, cnt_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [BE_W-1:0]   be_q;

   logic [BE_W-1:0]   be_in;
   logic              accept;
   logic              acc_en;
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic [BE_W-1:0]   acc_be;

`ifdef DMEM_BYTE_EN
   assign be_in = req_be;
`else
   assign be_in = '1;
`endif

   assign accept = req_valid && (state_q == IDLE);

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_en    = 1'b0;
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (WAIT_CYC == 0) begin
                  // No wait states: the access happens on the accept edge
                  // itself, so it must use the live request, not the latches.
                  state_d   = RESP;
                  acc_en    = 1'b1;
                  acc_we    = req_we;
                  acc_addr  = req_addr;
                  acc_wdata = req_wdata;
                  acc_be    = be_in;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               acc_en  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= be_in;
         end
      end
   end

   // The array's read register is the response data register: it only
   // changes on an access, so it stays stable through backpressure.
   dmem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (acc_en),
      .we_i    (acc_we),
      .be_i    (acc_be),
      .addr_i  (acc_addr),
      .wdata_i (acc_wdata),
      .rdata_o (resp_rdata)
   );

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Three responders (WAIT_CYC = 1, 0, 15) driven by directed transactions.
// A transaction-level model (word memory, pending request, due cycle) predicts
// req_ready/resp_valid/busy/resp_rdata every cycle; directed transactions add
// hand-computed expectations for data and latency. Define DMEM_BYTE_EN for
// both RTL and bench to exercise byte-masked stores.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int NI = 3;
   localparam int WC [NI] = '{1, 0, 15};
`ifdef DMEM_BYTE_EN
   localparam bit BYTE_EN = 1'b1;
`else
   localparam bit BYTE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid  [NI];
   logic        req_we     [NI];
   logic [6:0]  req_addr   [NI];
   logic [31:0] req_wdata  [NI];
   logic [3:0]  req_be     [NI];
   logic        resp_ready [NI];
   logic        req_ready  [NI];
   logic        resp_valid [NI];
   logic [31:0] resp_rdata [NI];
   logic        busy       [NI];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      dmem_responder #(
         .ADDR_W   (7),
         .DATA_W   (32),
         .WAIT_CYC ((k == 0) ? 1 : (k == 1) ? 0 : 15)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .req_valid  (req_valid[k]),
         .req_ready  (req_ready[k]),
         .req_we     (req_we[k]),
         .req_addr   (req_addr[k]),
         .req_wdata  (req_wdata[k]),
`ifdef DMEM_BYTE_EN
         .req_be     (req_be[k]),
`endif
         .resp_valid (resp_valid[k]),
         .resp_ready (resp_ready[k]),
         .resp_rdata (resp_rdata[k]),
         .busy       (busy[k])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [31:0] m_mem  [NI][128];
   bit          m_pend [NI];
   int          m_due  [NI];   // first cycle in which the response is visible
   bit          m_we   [NI];
   logic [6:0]  m_addr [NI];
   logic [31:0] m_wd   [NI];
   logic [3:0]  m_be   [NI];
   logic [31:0] m_rd   [NI];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NI; k++) begin
            m_pend[k] = 1'b0;
            m_rd[k]   = '0;
         end
      end else begin
         for (int k = 0; k < NI; k++) begin
            if (m_pend[k] && cyc >= m_due[k]) begin
               if (resp_ready[k]) m_pend[k] = 1'b0;
            end else if (!m_pend[k] && req_valid[k]) begin
               m_pend[k] = 1'b1;
               m_due[k]  = cyc + 1 + WC[k];
               m_we[k]   = req_we[k];
               m_addr[k] = req_addr[k];
               m_wd[k]   = req_wdata[k];
               m_be[k]   = req_be[k];
            end
            // The access happens on the edge ending the cycle before the due cycle.
            if (m_pend[k] && cyc + 1 == m_due[k]) begin
               if (m_we[k]) begin
                  logic [31:0] mask;
                  for (int b = 0; b < 4; b++)
                     mask[8*b +: 8] = (!BYTE_EN || m_be[k][b]) ? 8'hFF : 8'h00;
                  m_mem[k][m_addr[k]] = (m_mem[k][m_addr[k]] & ~mask) | (m_wd[k] & mask);
                  m_rd[k] = '0;
               end else begin
                  m_rd[k] = m_mem[k][m_addr[k]];
               end
            end
         end
         cyc++;
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < NI; k++) begin
            bit ev;
            ev = m_pend[k] && (cyc >= m_due[k]);
            check($sformatf("cyc_req_ready[%0d]", k),  32'(req_ready[k]),  32'(!m_pend[k]));
            check($sformatf("cyc_resp_valid[%0d]", k), 32'(resp_valid[k]), 32'(ev));
            check($sformatf("cyc_busy[%0d]", k),       32'(busy[k]),       32'(m_pend[k]));
            check($sformatf("cyc_resp_rdata[%0d]", k), resp_rdata[k],      m_rd[k]);
         end
      end
   end

   // One complete transaction on instance k with hand-computed expectations.
   // hold = cycles resp_ready stays low once resp_valid is up.
   task automatic xact(input int k, input string name, input logic we, input logic [6:0] a,
                       input logic [31:0] d, input logic [3:0] be, input int hold,
                       input logic [31:0] exp_rd, input int exp_lat);
      int n;
      int t0;
      @(negedge clk);
      req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_be[k] = be;
      resp_ready[k] = (hold == 0);
      n = 0;
      while (req_ready[k] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (req_ready[k] !== 1'b1) begin
         check({name, "_accept_timeout"}, 32'(req_ready[k]), 32'd1);
         req_valid[k] = 1'b0; resp_ready[k] = 1'b1;
         return;
      end
      t0 = cyc;
      @(posedge clk); #1;
      // Scramble the request so only latched values can produce the right result.
      req_valid[k] = 1'b0; req_we[k] = ~we; req_addr[k] = ~a; req_wdata[k] = ~d; req_be[k] = ~be;
      n = 0;
      do begin @(negedge clk); n++; end while (resp_valid[k] !== 1'b1 && n < 100);
      if (resp_valid[k] !== 1'b1) begin
         check({name, "_resp_timeout"}, 32'(resp_valid[k]), 32'd1);
         resp_ready[k] = 1'b1;
         return;
      end
      check({name, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
      check({name, "_rdata"}, resp_rdata[k], exp_rd);
      for (int i = 0; i < hold; i++) begin
         check({name, "_bp_valid"}, 32'(resp_valid[k]), 32'd1);
         check({name, "_bp_rdata"}, resp_rdata[k], exp_rd);
         check({name, "_bp_req_ready"}, 32'(req_ready[k]), 32'd0);
         @(negedge clk);
      end
      resp_ready[k] = 1'b1;
      @(negedge clk);
      check({name, "_ready_after_hs"}, 32'(req_ready[k]), 32'd1);
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
         req_wdata[k] = '0; req_be[k] = 4'hF; resp_ready[k] = 1'b1;
      end

      // 1. reset held for 3 cycles
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req_ready",  32'(req_ready[0]),  32'd1);
      check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
      check("rst_resp_rdata", resp_rdata[0],      32'd0);
      check("rst_busy",       32'(busy[0]),       32'd0);
      rst_n = 1'b1;

      // 2. store then load, WAIT_CYC = 1, plus address extremes
      xact(0, "st05",  1'b1, 7'h05, 32'hDEADBEEF, 4'hF, 0, 32'h0,        2);
      xact(0, "ld05",  1'b0, 7'h05, 32'h0,        4'hF, 0, 32'hDEADBEEF, 2);
      xact(0, "st00",  1'b1, 7'h00, 32'h11111111, 4'hF, 0, 32'h0,        2);
      xact(0, "st7f",  1'b1, 7'h7F, 32'h01234567, 4'hF, 0, 32'h0,        2);
      xact(0, "ld00",  1'b0, 7'h00, 32'h0,        4'hF, 0, 32'h11111111, 2);

      // 3. backpressure on a load of 7'h7F
      xact(0, "ld7f_bp", 1'b0, 7'h7F, 32'h0, 4'hF, 5, 32'h01234567, 2);
      xact(0, "ld05b",   1'b0, 7'h05, 32'h0, 4'hF, 0, 32'hDEADBEEF, 2);

      // 4. WAIT_CYC = 0 and WAIT_CYC = 15
      xact(1, "w0_st33", 1'b1, 7'h33, 32'hCAFEF00D, 4'hF, 0, 32'h0,        1);
      xact(1, "w0_ld33", 1'b0, 7'h33, 32'h0,        4'hF, 0, 32'hCAFEF00D, 1);
      xact(1, "w0_st7f", 1'b1, 7'h7F, 32'h0BADF00D, 4'hF, 2, 32'h0,        1);
      xact(1, "w0_ld7f", 1'b0, 7'h7F, 32'h0,        4'hF, 0, 32'h0BADF00D, 1);
      xact(2, "w15_st44", 1'b1, 7'h44, 32'h5A5AA5A5, 4'hF, 0, 32'h0,        16);
      xact(2, "w15_ld44", 1'b0, 7'h44, 32'h0,        4'hF, 0, 32'h5A5AA5A5, 16);

      // 5. reset during the WAIT of a store on the WAIT_CYC = 15 instance
      xact(2, "w15_st10_init", 1'b1, 7'h10, 32'h0, 4'hF, 0, 32'h0, 16);
      @(negedge clk);
      req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 7'h10;
      req_wdata[2] = 32'h12345678; req_be[2] = 4'hF;
      @(posedge clk); #1 req_valid[2] = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_busy_before", 32'(busy[2]), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_busy_after",  32'(busy[2]),      32'd0);
      check("rst_mid_ready_after", 32'(req_ready[2]), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      xact(2, "w15_ld10", 1'b0, 7'h10, 32'h0, 4'hF, 0, 32'h0, 16);
      xact(0, "ld05_after_rst", 1'b0, 7'h05, 32'h0, 4'hF, 0, 32'hDEADBEEF, 2);

      // 6. byte enables (full-word overwrite when the option is off)
      xact(0, "st20_ones", 1'b1, 7'h20, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 2);
`ifdef DMEM_BYTE_EN
      xact(0, "st20_be5",  1'b1, 7'h20, 32'h00000000, 4'b0101, 0, 32'h0,        2);
      xact(0, "ld20_be5",  1'b0, 7'h20, 32'h0,        4'b0000, 0, 32'hFF00FF00, 2);
      xact(0, "st20_be0",  1'b1, 7'h20, 32'h00000000, 4'b0000, 0, 32'h0,        2);
      xact(0, "ld20_be0",  1'b0, 7'h20, 32'h0,        4'b1010, 0, 32'hFF00FF00, 2);
`else
      xact(0, "st20_zero", 1'b1, 7'h20, 32'h00000000, 4'hF, 0, 32'h0, 2);
      xact(0, "ld20_zero", 1'b0, 7'h20, 32'h0,        4'hF, 0, 32'h0, 2);
`endif

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
